hamming_serial_secded_decoder: RTL
==================================

// Module: hamming_serial_secded_decoder
// PURPOSE
//  Parametrised serial Hamming decoder: collects one codeword bit-serially, computes syndrome, corrects a single-bit error,
//  presents K data bits on a valid/ready output register. Sits behind the UART receiver bit path, feeds byte/word reassembly.
//  Generalises the fixed (7,4) decoder: any 2^M-1 code, input/output handshakes, error reporting, optional SECDED.
// PARAMETERS
//  M   3  parity bit count; N=2^M-1 code bits, K=N-M data bits (legal 3..5)
// PORTS
//  clk               in   1  clock, all state on rising edge
//  rst_n             in   1  asynchronous, active-low reset
//  ena               in   1  block enable; low freezes all state
//  frame_clr         in   1  sync: discard partially received frame
//  bit_in            in   1  serial code bit
//  bit_valid         in   1  bit_in valid this cycle
//  bit_ready         out  1  block accepts bit this cycle
//  data_out          out  K  corrected data, LSB = lowest data position
//  data_valid        out  1  data_out/error flags valid
//  data_ready        in   1  consumer accepts output
//  err_corrected     out  1  single error corrected in this word
//  err_uncorrectable out  1  double error detected (SECDED only, else 0)
//  err_pos           out  M  corrected code position (0 = none / overall parity)
// BEHAVIOUR
//  - Code layout: positions 1..N, first bit received = position 1; parity at powers of 2, data at others, ascending -> data_out[0..K-1].
//  - Bit accepted when ena & bit_valid & bit_ready; position counter increments, last position -> DECODE.
//  - Syndrome S = XOR of indices of all positions holding 1 (M bits). S!=0 -> flip position S.
//  - FSM: COLLECT (bit_ready=ena) -> DECODE after last bit.
//    DECODE (bit_ready=0): if !data_valid or data_ready this cycle, load output regs, -> COLLECT; else stall in DECODE.
//  - Latency: last bit accepted edge T; data_valid high after edge T+1 if output register free.
//  - Output handshake: data_valid held with stable data/flags until data_valid & data_ready; then cleared unless reloaded same cycle.
//  - Simultaneous drain+load in DECODE: new word loaded, data_valid stays 1.
//  - Full-rate: next frame collects while previous word waits; only DECODE stalls.
//  - frame_clr (ena=1): counter->0, state->COLLECT, partial bits dropped; pending output word untouched. Ignored in DECODE.
//  - ena=0: no bit accepted, bit_ready=0, no state change; data_valid/data_out hold (consumer handshake still frozen).
//  - Reset: state COLLECT, counter 0, data_out 0, data_valid 0, err_* 0, err_pos 0; mid-frame reset drops partial frame.
//  - Counter wraps to 0 after final position; S out of range impossible since N=2^M-1.
// CONFIGURATION
//  HAMMING_SECDED_EN defined: frame = N+1 bits; bit N+1 (last) = overall even parity over all N+1 bits. P = parity check fail.
//    S=0,P=0: clean. S!=0,P=1: correct S, err_corrected=1. S=0,P=1: parity bit error, data clean, err_corrected=1, err_pos=0.
//    S!=0,P=0: double error, err_uncorrectable=1, err_corrected=0, data_out = uncorrected raw data, err_pos=0.
//  Not defined: frame = N bits, err_uncorrectable tied 0, no overall-parity logic.
// TESTING (M=3 unless noted; codeword shown pos7..pos1)
//  - Clean: 7'b1010101, data_ready=1 -> data_out=4'b1011, data_valid 1 cycle, err_corrected=0, err_pos=0.
//  - Single error: 7'b1000101 (pos5 flipped) -> data_out=4'b1011, err_corrected=1, err_pos=3'd5.
//  - Back-pressure: data_ready=0, send 2 clean frames -> first held stable; bit_ready=0 after second frame ends;
//    raise data_ready -> both words delivered in order, nothing lost.
//  - frame_clr after 3 bits, then full frame 7'b1010101 -> only one word 4'b1011 emitted; rst_n low mid-frame -> all outputs 0, next frame decodes.
//  - SECDED (macro on): 7'b1010101+parity 0 clean; flip pos2+pos5 -> err_uncorrectable=1;
//    flip parity bit only -> err_corrected=1, err_pos=0, data 4'b1011.
//  - M=4 (15,11): random data with single error at every position 1..15 -> corrected data matches, err_pos = injected position.

Source files
------------

// File: rtl/hamming_serial_secded_decoder.sv
// hamming_serial_secded_decoder: bit-serial Hamming (2^M-1, 2^M-1-M) decoder with single-error correction.
// Optional SECDED: define HAMMING_SECDED_EN to expect an extra overall even-parity bit at the end of each frame.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ena                low freezes every register, including the output handshake
//   frame_clr          drops a partially received frame (ignored while decoding)
//   bit_in/bit_valid/bit_ready            serial code input, first bit = position 1
//   data_out/data_valid/data_ready        decoded data word with valid/ready handshake
//   err_corrected/err_uncorrectable/err_pos  error report, held together with data_out
module hamming_serial_secded_decoder #(
    parameter int M = 3,
    localparam int N = (1 << M) - 1,
    localparam int K = N - M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         frame_clr,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic         bit_ready,
    output logic [K-1:0] data_out,
    output logic         data_valid,
    input  logic         data_ready,
    output logic         err_corrected,
    output logic         err_uncorrectable,
    output logic [M-1:0] err_pos
);
`ifdef HAMMING_SECDED_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif
    localparam logic [M:0] LAST = (M + 1)'(FL - 1);
    localparam logic [M:0] NL = (M + 1)'(N);
    typedef enum logic {COLLECT, DECODE} state_t;
    state_t state;
    logic [M:0] cnt;
    logic [N-1:0] code;
    logic [N-1:0] fixed;
    logic [M-1:0] syn;
    logic [K-1:0] dec_data;
    logic [M-1:0] dec_pos;
    logic dec_corr, dec_unc, hit;
    assign bit_ready = ena && state == COLLECT;
    assign hit = syn != '0;
`ifdef HAMMING_SECDED_EN
    // par = 1 means the overall parity check failed
    logic par;
    assign dec_unc = hit && !par;
    assign dec_corr = par;
    assign dec_pos = (hit && par) ? syn : '0;
`else
    assign dec_unc = 1'b0;
    assign dec_corr = hit;
    assign dec_pos = syn;
`endif
    // dec_pos = 0 flips nothing, so a double error passes the raw data through
    for (genvar i = 1; i <= N; i++) begin : g_pos
        assign fixed[i-1] = code[i-1] ^ (dec_pos == M'(i));
        if ((i & (i - 1)) != 0) begin : g_data
            assign dec_data[i - $clog2(i + 1) - 1] = fixed[i-1];
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= COLLECT;
            cnt <= '0;
            code <= '0;
            syn <= '0;
`ifdef HAMMING_SECDED_EN
            par <= 1'b0;
`endif
            data_out <= '0;
            data_valid <= 1'b0;
            err_corrected <= 1'b0;
            err_uncorrectable <= 1'b0;
            err_pos <= '0;
        end else if (ena) begin
            if (data_ready)
                data_valid <= 1'b0;
            if (state == COLLECT) begin
                if (frame_clr) begin
                    cnt <= '0;
                    syn <= '0;
`ifdef HAMMING_SECDED_EN
                    par <= 1'b0;
`endif
                end else if (bit_valid) begin
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LAST)
                        state <= DECODE;
                    // the SECDED parity position N+1 = 2^M truncates to 0 and leaves syn alone
                    if (bit_in)
                        syn <= syn ^ (cnt[M-1:0] + 1'b1);
                    if (cnt < NL)
                        code <= {bit_in, code[N-1:1]};
`ifdef HAMMING_SECDED_EN
                    par <= par ^ bit_in;
`endif
                end
            end else if (!data_valid || data_ready) begin
                data_out <= dec_data;
                data_valid <= 1'b1;
                err_corrected <= dec_corr;
                err_uncorrectable <= dec_unc;
                err_pos <= dec_pos;
                state <= COLLECT;
                syn <= '0;
`ifdef HAMMING_SECDED_EN
                par <= 1'b0;
`endif
            end
        end
endmodule
